// File: rtl/cska_bist_pkg.sv
// Shared types and constants for the carry-skip adder self-test driver.
// Holds the FSM encoding, the four directed corner vectors and the LFSR taps.
package cska_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_APPLY,
      ST_CHECK,
      ST_DONE
   } bist_state_t;

   localparam int ERR_W    = 16;
   localparam int LFSR_W   = 20;
   localparam int TAP_HI   = 19;
   localparam int TAP_LO   = 16;
   localparam int NUM_DIR  = 4;

   // Corner cases: zero, full-length ripple, max+max, all-propagate with no carry.
   localparam logic [9:0] DIR_A [NUM_DIR] = '{10'h000, 10'h3FF, 10'h3FF, 10'h2AA};
   localparam logic [9:0] DIR_B [NUM_DIR] = '{10'h000, 10'h001, 10'h3FF, 10'h155};

   // Fibonacci x^20 + x^17 + 1, shifting toward the MSB.
   function automatic logic [LFSR_W-1:0] lfsrStep(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
   endfunction

endpackage

// File: rtl/cska_bist_lfsr20.sv
// 20-bit pseudo-random operand source; load has priority over advance.
module cska_lfsr20
   import cska_bist_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RESET_SEED = 20'h5A5A5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_advance,
   input  logic [LFSR_W-1:0] i_seed,
   output logic [LFSR_W-1:0] o_state
);

   logic [LFSR_W-1:0] r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RESET_SEED;
      end else if (i_load) begin
         r_state <= i_seed;
      end else if (i_advance) begin
         r_state <= lfsrStep(r_state);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/cska_bist_driver.sv
// Self-test driver for the 10-bit carry-skip adder: applies directed and LFSR
// operand pairs, checks the adder result one cycle later and logs the first failure.
module cska_bist_driver
   import cska_bist_pkg::*;
#(
   parameter int                WIDTH       = 10,
   parameter int                NUM_VECTORS = 1024,
   parameter logic [LFSR_W-1:0] LFSR_SEED   = 20'h5A5A5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] dut_sum,
   input  logic             dut_cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH:0]   fail_got
);

   bist_state_t       r_state;
   bist_state_t       w_nextState;
   logic              w_accept;
   logic              w_lastVec;
   logic              w_advanceVec;
   logic              w_mismatch;
   logic [15:0]       r_index;
   logic [15:0]       w_nextIndex;
   logic [WIDTH-1:0]  r_opA;
   logic [WIDTH-1:0]  r_opB;
   logic [WIDTH-1:0]  w_nextA;
   logic [WIDTH-1:0]  w_nextB;
   logic [WIDTH:0]    w_expected;
   logic [WIDTH:0]    w_got;
   logic [ERR_W-1:0]  r_errCount;
   logic [WIDTH-1:0]  r_failA;
   logic [WIDTH-1:0]  r_failB;
   logic [WIDTH:0]    r_failGot;
   logic [LFSR_W-1:0] w_lfsrState;
   logic [LFSR_W-1:0] w_lfsrNext;
   logic              w_lfsrAdvance;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   assign w_lastVec = (r_index == 16'(NUM_VECTORS - 1));

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_nextState = ST_APPLY;
               w_accept    = 1'b1;
            end
         end
         ST_APPLY: w_nextState = ST_CHECK;
         ST_CHECK: w_nextState = w_lastVec ? ST_DONE : ST_APPLY;
         default:  w_nextState = ST_IDLE;
      endcase
   end

   assign w_advanceVec = (r_state == ST_CHECK) && !w_lastVec;
   assign w_nextIndex  = r_index + 16'd1;

   // The LFSR only steps for random vectors, so vector 4 is one step past the seed.
   assign w_lfsrNext    = lfsrStep(w_lfsrState);
   assign w_lfsrAdvance = w_advanceVec && (w_nextIndex >= 16'(NUM_DIR));

   cska_lfsr20 #(
      .RESET_SEED(LFSR_SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_accept),
      .i_advance(w_lfsrAdvance),
      .i_seed   (LFSR_SEED),
      .o_state  (w_lfsrState)
   );

   always_comb begin
      w_nextA = w_lfsrNext[LFSR_W-1 -: WIDTH];
      w_nextB = w_lfsrNext[WIDTH-1:0];
      if (w_nextIndex < 16'(NUM_DIR)) begin
         w_nextA = WIDTH'(DIR_A[w_nextIndex[1:0]]);
         w_nextB = WIDTH'(DIR_B[w_nextIndex[1:0]]);
      end
   end

   assign w_expected = {1'b0, r_opA} + {1'b0, r_opB};
   assign w_got      = {dut_cout, dut_sum};
   assign w_mismatch = (r_state == ST_CHECK) && (w_got != w_expected);

   // Operands, index and result log; a mismatch on the final vector is counted
   // on the same edge that enters DONE, so pass already reflects it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_index    <= '0;
         r_opA      <= '0;
         r_opB      <= '0;
         r_errCount <= '0;
         r_failA    <= '0;
         r_failB    <= '0;
         r_failGot  <= '0;
      end else if (w_accept) begin
         r_index    <= '0;
         r_opA      <= WIDTH'(DIR_A[0]);
         r_opB      <= WIDTH'(DIR_B[0]);
         r_errCount <= '0;
         r_failA    <= '0;
         r_failB    <= '0;
         r_failGot  <= '0;
      end else begin
         if (w_mismatch) begin
            if (r_errCount != '1) begin
               r_errCount <= r_errCount + ERR_W'(1);
            end
            if (r_errCount == '0) begin
               r_failA   <= r_opA;
               r_failB   <= r_opB;
               r_failGot <= w_got;
            end
         end
         if (w_advanceVec) begin
            r_index <= w_nextIndex;
            r_opA   <= w_nextA;
            r_opB   <= w_nextB;
         end
      end
   end

   assign op_a      = r_opA;
   assign op_b      = r_opB;
   assign busy      = (r_state == ST_APPLY) || (r_state == ST_CHECK);
   assign done      = (r_state == ST_DONE);
   assign pass      = done && (r_errCount == '0);
   assign err_count = r_errCount;
   assign fail_a    = r_failA;
   assign fail_b    = r_failB;
   assign fail_got  = r_failGot;

endmodule

// File: tb/tb_cska_bist_driver.sv
// Scoreboard bench for cska_bist_driver with an 8-vector run and a behavioural
// adder that can be made to fail (stuck cout, inverted sum).
module tb_cska_bist_driver;

   localparam int NV = 8;

   typedef struct {
      logic [9:0]  a;
      logic [9:0]  b;
      logic        chk;
      logic [10:0] sum;
   } vec_t;

   typedef struct {
      logic        pass;
      logic [15:0] err;
      logic [9:0]  fa;
      logic [9:0]  fb;
      logic [10:0] fg;
   } res_t;

   // Directed vectors plus LFSR states B4B4B, 69696, D2D2C, A5A58 split [19:10]/[9:0].
   localparam logic [9:0] VA [NV] = '{10'h000, 10'h3FF, 10'h3FF, 10'h2AA,
                                      10'h2D2, 10'h1A5, 10'h34B, 10'h296};
   localparam logic [9:0] VB [NV] = '{10'h000, 10'h001, 10'h3FF, 10'h155,
                                      10'h34B, 10'h296, 10'h12C, 10'h258};

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [9:0]  op_a;
   logic [9:0]  op_b;
   logic [9:0]  dut_sum;
   logic        dut_cout;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] err_count;
   logic [9:0]  fail_a;
   logic [9:0]  fail_b;
   logic [10:0] fail_got;
   logic        stuckCout;
   logic        invSum;
   logic [10:0] fullSum;

   int   errors = 0;
   int   checks = 0;
   vec_t vecQ[$];
   res_t resQ[$];

   cska_bist_driver #(
      .WIDTH      (10),
      .NUM_VECTORS(NV),
      .LFSR_SEED  (20'h5A5A5)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .dut_sum  (dut_sum),
      .dut_cout (dut_cout),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err_count(err_count),
      .fail_a   (fail_a),
      .fail_b   (fail_b),
      .fail_got (fail_got)
   );

   assign fullSum  = {1'b0, op_a} + {1'b0, op_b};
   assign dut_cout = stuckCout ? 1'b0 : fullSum[10];
   assign dut_sum  = invSum ? ~fullSum[9:0] : fullSum[9:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input res_t exp, input logic chkSum);
      for (int i = 0; i < NV; i++) begin
         vecQ.push_back('{VA[i], VB[i], chkSum && (i == 1), 11'h400});
      end
      resQ.push_back(exp);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input string name);
      bit seen = 0;
      for (int i = 0; i < 4 * NV + 10; i++) begin
         @(posedge clk);
         #2;
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: done never rose, got 0 expected 1", name);
      end
      @(negedge clk);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_op_a"}, 32'(op_a), 32'h0);
      checkOutput({tag, "_op_b"}, 32'(op_b), 32'h0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
      checkOutput({tag, "_done"}, 32'(done), 32'h0);
      checkOutput({tag, "_pass"}, 32'(pass), 32'h0);
      checkOutput({tag, "_err"}, 32'(err_count), 32'h0);
      checkOutput({tag, "_fail_a"}, 32'(fail_a), 32'h0);
      checkOutput({tag, "_fail_b"}, 32'(fail_b), 32'h0);
      checkOutput({tag, "_fail_got"}, 32'(fail_got), 32'h0);
   endtask

   // Monitor: pops a vector expectation on every APPLY cycle and a result
   // expectation when done rises; latency is measured from the accepted start.
   initial begin
      int   cyc = 0;
      int   startCyc = 0;
      int   phase = 0;
      logic prevBusy = 0;
      logic prevDone = 0;
      vec_t v;
      res_t r;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            prevBusy = 0;
            prevDone = 0;
            continue;
         end
         if (start && !prevBusy) begin
            startCyc = cyc;
            phase    = 0;
         end
         if (busy) begin
            if (phase % 2 == 0) begin
               if (vecQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL vec_underflow: got vector %0h/%0h expected none", op_a, op_b);
               end else begin
                  v = vecQ.pop_front();
                  checkOutput("vec_op_a", 32'(op_a), 32'(v.a));
                  checkOutput("vec_op_b", 32'(op_b), 32'(v.b));
                  if (v.chk) begin
                     checkOutput("vec1_adder_out", 32'({dut_cout, dut_sum}), 32'(v.sum));
                  end
               end
            end
            phase++;
         end
         if (done && !prevDone) begin
            checkOutput("run_latency", 32'(cyc - startCyc), 32'(2 * NV));
            if (resQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL res_underflow: got done expected none");
            end else begin
               r = resQ.pop_front();
               checkOutput("res_pass", 32'(pass), 32'(r.pass));
               checkOutput("res_err_count", 32'(err_count), 32'(r.err));
               checkOutput("res_fail_a", 32'(fail_a), 32'(r.fa));
               checkOutput("res_fail_b", 32'(fail_b), 32'(r.fb));
               checkOutput("res_fail_got", 32'(fail_got), 32'(r.fg));
            end
         end
         prevBusy = busy;
         prevDone = done;
      end
   end

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      stuckCout = 1'b0;
      invSum    = 1'b0;
      #12;
      checkResetState("reset");
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] correct adder run");
      applyStimulus('{1'b1, 16'd0, 10'h000, 10'h000, 11'h000}, 1'b1);
      waitDone("correct_run");

      // Cout stuck low: vectors 1, 2 and all four random vectors carry out.
      $display("[TB] stuck-at-0 cout run");
      stuckCout = 1'b1;
      applyStimulus('{1'b0, 16'd6, 10'h3FF, 10'h001, 11'h000}, 1'b0);
      waitDone("stuck_cout_run");
      stuckCout = 1'b0;

      $display("[TB] inverted sum run");
      invSum = 1'b1;
      applyStimulus('{1'b0, 16'd8, 10'h000, 10'h000, 11'h3FF}, 1'b0);
      waitDone("inv_sum_run");
      invSum = 1'b0;

      // Abort during vector 4 with errors already logged, then replay from vector 0.
      $display("[TB] reset mid-run");
      stuckCout = 1'b1;
      applyStimulus('{1'b0, 16'd0, 10'h000, 10'h000, 11'h000}, 1'b0);
      repeat (8) @(negedge clk);
      checkOutput("pre_abort_err", 32'(err_count), 32'd2);
      rst_n = 1'b0;
      #1;
      checkResetState("abort");
      vecQ.delete();
      resQ.delete();
      stuckCout = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus('{1'b1, 16'd0, 10'h000, 10'h000, 11'h000}, 1'b1);
      waitDone("replay_run");

      $display("[TB] start while busy");
      applyStimulus('{1'b1, 16'd0, 10'h000, 10'h000, 11'h000}, 1'b0);
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone("busy_start_run");

      checkOutput("done_holds", 32'(done), 32'h1);
      checkOutput("vec_queue_empty", 32'(vecQ.size()), 32'h0);
      checkOutput("res_queue_empty", 32'(resQ.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
